// File: rtl/level_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : level_unpacker
// Brief    : Unpacks 32-bit words of signed levels LSB-first, one level/cycle.
// Revision : 1.0
// ============================================================================
module level_unpacker #(
  parameter int LEVEL_W     = 8,
  parameter int DEQ_LATENCY = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      s_data,
  input  logic [4:0]       s_nlev,
  input  logic             s_is_weight,
  input  logic             s_last,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [31:0]      level_int,
  output logic             is_weight,
  output logic             lvl_valid,
  output logic             w_valid,
  output logic             w_last,
  output logic [CNT_W-1:0] level_count
);

  localparam int          c_LPW_I = 32 / LEVEL_W;
  localparam logic [4:0]  c_LPW   = 5'(c_LPW_I);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_data;
  logic [4:0]          r_n;
  logic [4:0]          r_idx;
  logic                r_wt;
  logic                r_last;
  logic                r_lvl_last;
  logic [1:0]          r_dly [DEQ_LATENCY];
  logic                w_accept;
  logic                w_idx_last;
  logic                w_emit;
  logic [4:0]          w_n_in;
  logic [LEVEL_W-1:0]  w_lvl;
  logic [31:0]         w_lvl_sext;
  logic [CNT_W-1:0]    w_cnt_base;
  logic [CNT_W-1:0]    w_cnt_nxt;

  // A count of 0 or beyond the word capacity means a full word.
  assign w_n_in     = ((s_nlev == 5'd0) || (s_nlev > c_LPW)) ? c_LPW : s_nlev;
  assign w_idx_last = (r_idx == (r_n - 5'd1));
  assign w_emit     = (r_state == ST_EMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (w_idx_last) begin
          s_ready     = 1'b1;
          w_state_nxt = s_valid ? ST_EMIT : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_accept = s_valid & s_ready;
  end

  always_comb begin
    w_lvl = '0;
    for (int k = 0; k < c_LPW_I; k++) begin
      if (r_idx == 5'(k)) begin
        w_lvl = r_data[k*LEVEL_W +: LEVEL_W];
      end
    end
  end

  assign w_lvl_sext = {{(32-LEVEL_W){w_lvl[LEVEL_W-1]}}, w_lvl};

  // The count restarts after a tensor's last level; a new level on that cycle makes it 1.
  assign w_cnt_base = r_lvl_last ? '0 : level_count;
  assign w_cnt_nxt  = (w_emit && (w_cnt_base != {CNT_W{1'b1}})) ? w_cnt_base + 1'b1 : w_cnt_base;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data      <= '0;
      r_n         <= '0;
      r_idx       <= '0;
      r_wt        <= 1'b0;
      r_last      <= 1'b0;
      r_lvl_last  <= 1'b0;
      level_int   <= '0;
      is_weight   <= 1'b0;
      lvl_valid   <= 1'b0;
      level_count <= '0;
    end else begin
      if (w_accept) begin
        r_data <= s_data;
        r_n    <= w_n_in;
        r_wt   <= s_is_weight;
        r_last <= s_last;
        r_idx  <= '0;
      end else if (w_emit) begin
        r_idx  <= r_idx + 5'd1;
      end

      if (w_emit) begin
        level_int  <= w_lvl_sext;
        lvl_valid  <= 1'b1;
        is_weight  <= r_wt;
        r_lvl_last <= r_last & w_idx_last;
      end else begin
        level_int  <= '0;
        lvl_valid  <= 1'b0;
        r_lvl_last <= 1'b0;
      end

      level_count <= w_cnt_nxt;
    end
  end

  // Tag pipeline matching the dequantizer latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEQ_LATENCY; i++) begin
        r_dly[i] <= 2'b00;
      end
    end else begin
      r_dly[0] <= {lvl_valid, r_lvl_last};
      for (int i = 1; i < DEQ_LATENCY; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
    end
  end

  assign w_valid = r_dly[DEQ_LATENCY-1][1];
  assign w_last  = r_dly[DEQ_LATENCY-1][0];

endmodule
`default_nettype wire

// File: tb/tb_level_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_level_unpacker
// Brief    : Randomized and directed bench with a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_level_unpacker;

  localparam int c_DL    = 8;
  localparam int c_CNT_W = 3;

  logic        clk;
  logic        rst;
  logic [31:0] s_data;
  logic [4:0]  s_nlev;
  logic        s_is_weight;
  logic        s_last;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] level_int;
  logic        is_weight;
  logic        lvl_valid;
  logic        w_valid;
  logic        w_last;
  logic [c_CNT_W-1:0] level_count;

  logic [31:0] u4_data;
  logic [4:0]  u4_nlev;
  logic        u4_wt_in;
  logic        u4_valid;
  logic        u4_ready;
  logic [31:0] u4_level;
  logic        u4_wt;
  logic        u4_lvl_valid;
  logic        u4_w_valid;
  logic        u4_w_last;
  logic [15:0] u4_count;

  level_unpacker #(.LEVEL_W(8), .DEQ_LATENCY(c_DL), .CNT_W(c_CNT_W)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_nlev(s_nlev), .s_is_weight(s_is_weight),
    .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready), .level_int(level_int),
    .is_weight(is_weight), .lvl_valid(lvl_valid), .w_valid(w_valid), .w_last(w_last),
    .level_count(level_count)
  );

  level_unpacker #(.LEVEL_W(4), .DEQ_LATENCY(2), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .s_data(u4_data), .s_nlev(u4_nlev), .s_is_weight(u4_wt_in),
    .s_last(1'b0), .s_valid(u4_valid), .s_ready(u4_ready), .level_int(u4_level),
    .is_weight(u4_wt), .lvl_valid(u4_lvl_valid), .w_valid(u4_w_valid), .w_last(u4_w_last),
    .level_count(u4_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Reference model: pending levels of the current word plus output history.
  logic [31:0] q_lvl [$];
  logic [1:0]  hist  [$];
  logic        cur_wt, cur_last;
  logic [31:0] e_level;
  logic        e_valid, e_wt, e_last_lvl;
  int          e_cnt;
  logic        last_acc;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endfunction

  function automatic void model_reset();
    q_lvl.delete();
    hist.delete();
    cur_wt     = 1'b0;
    cur_last   = 1'b0;
    e_level    = '0;
    e_valid    = 1'b0;
    e_wt       = 1'b0;
    e_last_lvl = 1'b0;
    e_cnt      = 0;
  endfunction

  task automatic cycle();
    logic        exp_ready;
    logic        acc;
    logic        lastflag;
    logic [1:0]  wexp;
    int          base;
    int          n;
    int          v;
    exp_ready = (q_lvl.size() <= 1);
    chk("s_ready", {31'b0, s_ready}, {31'b0, exp_ready});
    acc = s_valid && exp_ready;
    @(posedge clk);
    if (q_lvl.size() > 0) begin
      e_level  = q_lvl.pop_front();
      e_valid  = 1'b1;
      e_wt     = cur_wt;
      lastflag = (q_lvl.size() == 0) && cur_last;
    end else begin
      e_level  = '0;
      e_valid  = 1'b0;
      lastflag = 1'b0;
    end
    base = e_last_lvl ? 0 : e_cnt;
    if (e_valid && base < (1 << c_CNT_W) - 1) base++;
    e_cnt      = base;
    e_last_lvl = lastflag;
    if (acc) begin
      n = (s_nlev == 0 || s_nlev > 4) ? 4 : int'(s_nlev);
      for (int k = 0; k < n; k++) begin
        v = int'((s_data >> (8 * k)) & 32'hFF);
        if (v >= 128) v = v - 256;
        q_lvl.push_back(32'(v));
      end
      cur_wt   = s_is_weight;
      cur_last = s_last;
    end
    last_acc = acc;
    hist.push_back({e_valid, lastflag});
    wexp = (hist.size() > c_DL) ? hist[hist.size() - 1 - c_DL] : 2'b00;
    #1;
    chk("level_int",   level_int,            e_level);
    chk("lvl_valid",   {31'b0, lvl_valid},   {31'b0, e_valid});
    chk("is_weight",   {31'b0, is_weight},   {31'b0, e_wt});
    chk("w_valid",     {31'b0, w_valid},     {31'b0, wexp[1]});
    chk("w_last",      {31'b0, w_last},      {31'b0, wexp[0]});
    chk("level_count", 32'(level_count),     32'(e_cnt));
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] n, input logic wt, input logic lst);
    bit done;
    done        = 1'b0;
    s_data      = d;
    s_nlev      = n;
    s_is_weight = wt;
    s_last      = lst;
    s_valid     = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      cycle();
      done = last_acc;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
    s_data  = $urandom;
    s_nlev  = 5'($urandom_range(0, 31));
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    for (int t = 0; t < n; t++) cycle();
  endtask

  initial begin
    logic [31:0] ex1 [4];
    ex1[0] = 32'h0000007F; ex1[1] = 32'h00000001; ex1[2] = 32'hFFFFFFFF; ex1[3] = 32'hFFFFFF80;
    rst = 1'b0; s_data = '0; s_nlev = '0; s_is_weight = 1'b0; s_last = 1'b0; s_valid = 1'b0;
    u4_data = '0; u4_nlev = '0; u4_wt_in = 1'b0; u4_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", level_int, 32'd0);
    chk("rst_valid", {31'b0, lvl_valid}, 32'd0);
    chk("rst_count", 32'(level_count), 32'd0);
    rst = 1'b1;
    idle(2);

    // Single word, explicit constants.
    send(32'h80FF017F, 5'd4, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("ex1_ready", {31'b0, s_ready}, {31'b0, (k == 3)});
      cycle();
      chk("ex1_level", level_int, ex1[k]);
    end
    idle(3);

    // Back-to-back, then short last word followed by a default-size word.
    send(32'h11223344, 5'd4, 1'b1, 1'b0);
    send(32'h8899AABB, 5'd4, 1'b1, 1'b1);
    send(32'h0000FE05, 5'd2, 1'b1, 1'b1);
    send(32'h7F80C001, 5'd0, 1'b1, 1'b0);
    idle(2);

    // Weight word then activation word.
    send(32'h01020304, 5'd3, 1'b1, 1'b1);
    send(32'hF0F1F2F3, 5'd2, 1'b0, 1'b1);
    idle(c_DL + 2);

    // LEVEL_W=4 instance: 0x8F, two levels, then held is_weight on idle.
    u4_data = 32'h0000008F; u4_nlev = 5'd2; u4_wt_in = 1'b1; u4_valid = 1'b1;
    cycle();
    u4_valid = 1'b0; u4_wt_in = 1'b0; u4_data = 32'hFFFFFFFF;
    cycle();
    chk("u4_lvl0", u4_level, 32'hFFFFFFFF);
    cycle();
    chk("u4_lvl1", u4_level, 32'hFFFFFFF8);
    chk("u4_v1", {31'b0, u4_lvl_valid}, 32'd1);
    cycle();
    chk("u4_idle_v", {31'b0, u4_lvl_valid}, 32'd0);
    chk("u4_idle_lvl", u4_level, 32'd0);
    chk("u4_idle_wt", {31'b0, u4_wt}, 32'd1);

    // Asynchronous reset halfway through a word.
    send(32'hDEADBEEF, 5'd4, 1'b1, 1'b1);
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    chk("arst_level", level_int, 32'd0);
    chk("arst_valid", {31'b0, lvl_valid}, 32'd0);
    chk("arst_wt", {31'b0, is_weight}, 32'd0);
    chk("arst_wvalid", {31'b0, w_valid}, 32'd0);
    chk("arst_wlast", {31'b0, w_last}, 32'd0);
    chk("arst_count", 32'(level_count), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    send(32'h00000102, 5'd2, 1'b0, 1'b1);
    idle(c_DL + 3);

    // Randomized words with random gaps, sizes (including oversize) and tags.
    for (int w = 0; w < 60; w++) begin
      idle($urandom_range(0, 2));
      send($urandom, 5'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0));
    end
    idle(c_DL + 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
